// File: rtl/mult_share_pkg.sv
// Shared types and defaults for the shared multiplier controller (mult_share_ctrl).
package mult_share_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CLR    = 3'd1,
    LAUNCH = 3'd2,
    WAIT   = 3'd3,
    RESP   = 3'd4
  } state_t;

  localparam int DEF_NUM_BITS   = 7;
  localparam int DEF_N_REQ      = 2;
  localparam int DEF_MUL_CYCLES = 16;
  localparam int CNT_W          = $clog2(DEF_MUL_CYCLES);

  // Wait counter must hold MUL_CYCLES-1; never narrower than one bit.
  function automatic int cnt_width(input int cycles);
    return (cycles > 1) ? $clog2(cycles) : 1;
  endfunction

endpackage

// File: rtl/mult_rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant, pointer advances past the winner on grant.
module mult_rr_arbiter #(
  parameter int N_REQ = 2,
  parameter int PW    = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req_valid,
  input  logic             grant_en,
  output logic [N_REQ-1:0] grant,
  output logic [PW-1:0]    grant_id
);

  logic [PW-1:0] ptr;
  logic [PW-1:0] ptr_n;
  logic [PW-1:0] idx;
  logic          found;

  // Scan starting at the pointer; first valid requester in that order wins.
  always_comb begin
    grant    = '0;
    grant_id = '0;
    found    = 1'b0;
    idx      = '0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = PW'((int'(ptr) + k) % N_REQ);
      if (!found && grant_en && req_valid[idx]) begin
        found       = 1'b1;
        grant[idx]  = 1'b1;
        grant_id    = idx;
      end
    end
  end

  always_comb begin
    ptr_n = ptr;
    if (found) begin
      if (int'(grant_id) == N_REQ - 1) ptr_n = '0;
      else                             ptr_n = grant_id + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) ptr <= '0;
    else      ptr <= ptr_n;
  end

endmodule

// File: rtl/mult_share_ctrl.sv
// Constant-time arbiter/controller sharing one sequential multiplier among N_REQ requesters.
// Optional taint tracking is enabled by defining MULT_SHARE_TAINT_EN.
module mult_share_ctrl
  import mult_share_pkg::*;
#(
  parameter int NUM_BITS   = DEF_NUM_BITS,
  parameter int N_REQ      = DEF_N_REQ,
  parameter int MUL_CYCLES = DEF_MUL_CYCLES
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_REQ-1:0]          req_valid,
  output logic [N_REQ-1:0]          req_ready,
  input  logic [N_REQ*NUM_BITS-1:0] req_a,
  input  logic [N_REQ*NUM_BITS-1:0] req_b,
`ifdef MULT_SHARE_TAINT_EN
  input  logic [N_REQ-1:0]          req_a_t,
  input  logic [N_REQ-1:0]          req_b_t,
  output logic                      resp_t,
`endif
  output logic [N_REQ-1:0]          resp_valid,
  output logic [2*NUM_BITS-1:0]     resp_product,
  output logic                      mul_rst,
  output logic                      mul_start,
  output logic [NUM_BITS-1:0]       mul_multiplier,
  output logic [NUM_BITS-1:0]       mul_multiplicand,
  output logic                      mul_start_t,
  output logic                      mul_multiplier_t,
  output logic                      mul_multiplicand_t,
  input  logic [2*NUM_BITS-1:0]     mul_product,
  output logic [2:0]                dbg_state
);

  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CW = cnt_width(MUL_CYCLES);

  // Handshake: req_valid is held by the requester until req_ready (one-hot, IDLE only)
  // is seen high at a rising edge; that edge transfers the operands. resp_valid is a
  // single-cycle strobe with no back-pressure.

  state_t        state, state_n;
  logic [CW-1:0] cnt;
  logic [PW-1:0] id_q;
  logic [PW-1:0] grant_id;
  logic [NUM_BITS-1:0] a_q, b_q;
  logic          grant_en;
  logic          wait_done;

  assign grant_en  = (state == IDLE);
  assign wait_done = (state == WAIT) && (cnt == '0);

  mult_rr_arbiter #(
    .N_REQ (N_REQ),
    .PW    (PW)
  ) u_arb (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .grant_en  (grant_en),
    .grant     (req_ready),
    .grant_id  (grant_id)
  );

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (|req_ready) state_n = CLR;
      CLR:     state_n = LAUNCH;
      LAUNCH:  state_n = WAIT;
      WAIT:    if (cnt == '0) state_n = RESP;
      RESP:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // The multiplier's done flag is deliberately ignored; the fixed count keeps latency data-independent.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state        <= IDLE;
      cnt          <= '0;
      id_q         <= '0;
      a_q          <= '0;
      b_q          <= '0;
      resp_valid   <= '0;
      resp_product <= '0;
    end else begin
      state      <= state_n;
      resp_valid <= '0;
      if (|req_ready) begin
        id_q <= grant_id;
        a_q  <= req_a[grant_id*NUM_BITS +: NUM_BITS];
        b_q  <= req_b[grant_id*NUM_BITS +: NUM_BITS];
      end
      if (state == LAUNCH)                cnt <= CW'(MUL_CYCLES - 1);
      else if (state == WAIT && cnt != '0) cnt <= cnt - CW'(1);
      if (wait_done) begin
        resp_product <= mul_product;
        resp_valid   <= N_REQ'(1) << id_q;
      end
    end
  end

  assign mul_rst          = !rst || (state == CLR);
  assign mul_start        = rst && (state == LAUNCH);
  assign mul_multiplier   = a_q;
  assign mul_multiplicand = b_q;
  assign mul_start_t      = 1'b0;
  assign dbg_state        = state;

`ifdef MULT_SHARE_TAINT_EN
  logic at_q, bt_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      at_q   <= 1'b0;
      bt_q   <= 1'b0;
      resp_t <= 1'b0;
    end else begin
      if (|req_ready) begin
        at_q <= req_a_t[grant_id];
        bt_q <= req_b_t[grant_id];
      end
      if (wait_done) resp_t <= at_q | bt_q;
    end
  end

  assign mul_multiplier_t   = at_q;
  assign mul_multiplicand_t = bt_q;
`else
  assign mul_multiplier_t   = 1'b0;
  assign mul_multiplicand_t = 1'b0;
`endif

endmodule

// File: doc/mult_share_ctrl.md
Name: mult_share_ctrl

Overview:
- Constant-time controller and arbiter that shares one sequential taint-tracking multiplier between N_REQ requesters.
- Grants requesters round-robin, then resets, launches and waits on the multiplier for a fixed cycle count; the multiplier's done status is never consulted.
- Captures the product and routes it back with a one-hot response strobe and result taint.
- Every transaction latency is independent of operand values and taint, so no timing channel leaks.

Parameters:
- NUM_BITS, 7: operand width; product is 2*NUM_BITS.
- N_REQ, 2: number of requesters (2..4).
- MUL_CYCLES, 16: fixed wait after launch. Must be >= the multiplier's worst-case latency.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-low reset.
- req_valid  in  N_REQ  request pending; held high until granted.
- req_ready  out  N_REQ  one-hot grant; combinational, IDLE state only.
- req_a  in  N_REQ*NUM_BITS  multiplier operands, requester i at [i*NUM_BITS +: NUM_BITS].
- req_b  in  N_REQ*NUM_BITS  multiplicand operands, same packing.
- req_a_t, req_b_t  in  N_REQ  per-requester operand taint (MULT_SHARE_TAINT_EN only).
- resp_valid  out  N_REQ  one-cycle one-hot completion strobe.
- resp_product  out  2*NUM_BITS  registered product; holds until the next completion.
- resp_t  out  1  result taint (MULT_SHARE_TAINT_EN only).
- mul_rst  out  1  active-high reset to the multiplier.
- mul_start  out  1  start pulse to the multiplier.
- mul_multiplier, mul_multiplicand  out  NUM_BITS  latched operands.
- mul_start_t, mul_multiplier_t, mul_multiplicand_t  out  1  taint to the multiplier.
- mul_product  in  2*NUM_BITS  multiplier result.

Behaviour:
- Reset (rst==0 at an edge):
  - State goes to IDLE; the round-robin pointer makes requester 0 highest priority.
  - resp_valid=0, resp_product=0, resp_t=0, mul_start=0, operand and taint regs=0.
  - mul_rst=1 while rst is low.
  - Reset mid-transaction aborts it: no resp_valid is ever issued for it.
- State sequence: IDLE -> CLR -> LAUNCH -> WAIT -> RESP -> IDLE.
- IDLE:
  - If any req_valid, the arbiter grants exactly one (req_ready one-hot that cycle).
  - On that edge it latches the requester's operands, taint and id, and moves to CLR.
  - req_ready is 0 in all other states; requests arriving while busy wait.
- CLR: mul_rst=1 for one cycle.
- LAUNCH: mul_start=1 for one cycle; mul_start_t=0 (the start decision is untainted).
- WAIT:
  - A counter loads MUL_CYCLES-1 and decrements each cycle.
  - At 0, mul_product is registered into resp_product.
- RESP: resp_valid[id]=1 for exactly one cycle, then IDLE.
- Latency: grant edge to resp_valid is exactly MUL_CYCLES+3 cycles for all operands and taints.
- Back-to-back throughput is one op per MUL_CYCLES+4 cycles.
- Round-robin:
  - After a grant to i, priority order becomes i+1, i+2, ..., wrapping modulo N_REQ.
  - With a single valid requester, it is granted regardless of the pointer.
- Arithmetic: unsigned; 2*NUM_BITS product never overflows (127*127=16129).
- Simultaneous events: a new req_valid during RESP is not granted until the following IDLE cycle.

Optional Feature:
- MULT_SHARE_TAINT_EN defined:
  - Taint ports are present.
  - mul_multiplier_t = latched req_a_t[id]; mul_multiplicand_t = latched req_b_t[id].
  - resp_t = req_a_t[id] | req_b_t[id], registered alongside resp_product.
  - Timing is unchanged by taint.
- Not defined: the req_*_t inputs and resp_t are absent; mul_*_t outputs are tied to 0.

Decomposition:
- Package mult_share_pkg holds:
  - state typedef (IDLE, CLR, LAUNCH, WAIT, RESP);
  - default NUM_BITS and MUL_CYCLES constants;
  - wait-counter width, $clog2(MUL_CYCLES).
- One sub-module, mult_rr_arbiter: combinational one-hot grant from req_valid and the pointer, plus a registered pointer update on grant.

Test Plan:
- Reset, then req0 15x15 → req_ready[0] for 1 cycle; resp_valid[0] exactly 19 cycles later; resp_product=225.
- Reset, then req0 92x75 and req1 42x78 valid on the same cycle → req0 granted first with 6900, then req1 with 3276; resp_valid strobes 20 cycles apart.
- Both requesters hold valid for 4 transactions (1x2, 0x12, 0x0, 127x127) → grant order 0,1,0,1; products 2, 0, 0, 16129.
- Latency check: 0x0 and 127x127 both complete in exactly 19 cycles; resp_product holds between strobes.
- rst low during WAIT of req1 42x78 → no resp_valid; mul_rst=1; the next req1 1x2 completes with 2 and correct latency.
- MULT_SHARE_TAINT_EN: req1 with req_a_t=1 → resp_t=1 and mul_multiplier_t=1; req0 untainted → resp_t=0; latency identical in both cases.
